vga_fb_arbiter: RTL and testbench

- Shares one single-port, registered-read framebuffer RAM between VGA scan-out and a pixel writer (drawing engine or host).
- Takes the column/row counters from the VGA sync-pulse counter block and issues one display read per framebuffer cell, at fixed slots.
- Grants all other RAM cycles to the writer through a req/ack handshake.
- Drives scaled-up pixel data to the colour output stage.

---
 rtl/vga_fb_arbiter.sv | 131 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port, registered-read framebuffer RAM
// between VGA scan-out and a pixel writer.
//
// Display reads occur at fixed slots (first column of each visible cell).
// The writer gets every other RAM cycle through a req/ack handshake.
// Cell data is replicated across the cell and presented on o_Pixel.
//
// Ports:
//   i_Clk, i_Rst                 pixel clock, async active-high reset
//   i_Col_Count, i_Row_Count     scan position from the sync counter block
//   o_Mem_Addr/We/Wdata          registered RAM command
//   i_Mem_Rdata                  RAM read data, one edge after the address
//   i_Wr_Req/Addr/Data, o_Wr_Ack writer handshake (ack is a one-cycle pulse)
//   o_Pixel, o_Active            cell data and visible flag, aligned
//
// Optional build macro FB_ARB_VBLANK_WRITE_ONLY_EN: writer grants are
// restricted to vertical blanking (row >= ACTIVE_ROWS).
module vga_fb_arbiter #(
    parameter int unsigned ACTIVE_COLS = 640,
    parameter int unsigned ACTIVE_ROWS = 480,
    parameter int unsigned SCALE_LOG2  = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 13
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [9:0]            i_Col_Count,
    input  logic [9:0]            i_Row_Count,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic                  o_Mem_We,
    output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
    input  logic                  i_Wr_Req,
    input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic                  o_Wr_Ack,
    output logic [DATA_WIDTH-1:0] o_Pixel,
    output logic                  o_Active
);

    localparam int unsigned FB_COLS   = ACTIVE_COLS >> SCALE_LOG2;
    localparam int unsigned FB_ROWS   = ACTIVE_ROWS >> SCALE_LOG2;
    localparam int unsigned FB_CELLS  = FB_COLS * FB_ROWS;
    localparam int unsigned CELL_MASK = (32'd1 << SCALE_LOG2) - 32'd1;

    logic                  visible_c;
    logic                  slot_c;
    logic                  wr_window_c;
    logic                  grant_c;
    logic [ADDR_WIDTH-1:0] disp_addr_c;

    // Pipeline flags: stage 1 aligns with the address, stage 2 with rdata.
    logic slot_d1, slot_d2;
    logic vis_d1, vis_d2;

    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic                  mem_we_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  wr_ack_nxt;
    logic [DATA_WIDTH-1:0] pixel_nxt;

    // Scan-position decode: visible area, display slot, cell address.
    always_comb begin
        visible_c   = (32'(i_Col_Count) < ACTIVE_COLS) && (32'(i_Row_Count) < ACTIVE_ROWS);
        slot_c      = visible_c && ((32'(i_Col_Count) & CELL_MASK) == 32'd0);
        disp_addr_c = ADDR_WIDTH'(((32'(i_Row_Count) >> SCALE_LOG2) * FB_COLS)
                                  + (32'(i_Col_Count) >> SCALE_LOG2));
`ifdef FB_ARB_VBLANK_WRITE_ONLY_EN
        wr_window_c = (32'(i_Row_Count) >= ACTIVE_ROWS);
`else
        wr_window_c = 1'b1;
`endif
        // Blocking on o_Wr_Ack keeps a still-held, already-served request
        // from being written a second time.
        grant_c = !slot_c && i_Wr_Req && !o_Wr_Ack && wr_window_c;
    end

    // Next-value logic for the RAM command, handshake and pixel output.
    always_comb begin
        mem_addr_nxt  = o_Mem_Addr;
        mem_we_nxt    = 1'b0;
        mem_wdata_nxt = o_Mem_Wdata;
        wr_ack_nxt    = 1'b0;

        if (slot_c) begin
            mem_addr_nxt = disp_addr_c;
        end else if (grant_c) begin
            mem_addr_nxt  = i_Wr_Addr;
            mem_wdata_nxt = i_Wr_Data;
            // Out-of-range cells are acked but dropped.
            mem_we_nxt    = (32'(i_Wr_Addr) < FB_CELLS);
            wr_ack_nxt    = 1'b1;
        end

        if (!vis_d2) begin
            pixel_nxt = '0;
        end else if (slot_d2) begin
            pixel_nxt = i_Mem_Rdata;
        end else begin
            pixel_nxt = o_Pixel;
        end
    end

    // State registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Mem_Addr  <= '0;
            o_Mem_We    <= 1'b0;
            o_Mem_Wdata <= '0;
            o_Wr_Ack    <= 1'b0;
            o_Pixel     <= '0;
            o_Active    <= 1'b0;
            slot_d1     <= 1'b0;
            slot_d2     <= 1'b0;
            vis_d1      <= 1'b0;
            vis_d2      <= 1'b0;
        end else begin
            o_Mem_Addr  <= mem_addr_nxt;
            o_Mem_We    <= mem_we_nxt;
            o_Mem_Wdata <= mem_wdata_nxt;
            o_Wr_Ack    <= wr_ack_nxt;
            o_Pixel     <= pixel_nxt;
            o_Active    <= vis_d2;
            slot_d1     <= slot_c;
            slot_d2     <= slot_d1;
            vis_d1      <= visible_c;
            vis_d2      <= vis_d1;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural registered-read RAM.
module tb_vga_fb_arbiter;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic [9:0]  col, row;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        wr_req;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [7:0]  pixel;
    logic        active;

    bit [7:0] ram [0:8191];
    int       wr_cnt = 0;
    int       n_vec  = 0;
    int       n_err  = 0;

    always #5 i_Clk = ~i_Clk;

    vga_fb_arbiter dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Col_Count (col),
        .i_Row_Count (row),
        .o_Mem_Addr  (mem_addr),
        .o_Mem_We    (mem_we),
        .o_Mem_Wdata (mem_wdata),
        .i_Mem_Rdata (mem_rdata),
        .i_Wr_Req    (wr_req),
        .i_Wr_Addr   (wr_addr),
        .i_Wr_Data   (wr_data),
        .o_Wr_Ack    (wr_ack),
        .o_Pixel     (pixel),
        .o_Active    (active)
    );

    // Single-port RAM with registered read.
    always @(posedge i_Clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge i_Clk);
        #1;
    endtask

    initial begin
        i_Rst   = 1'b1;
        col     = '0;
        row     = '0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        step;
        check("reset_outs", {mem_addr, mem_we, mem_wdata, wr_ack, pixel, active}, 32'd0);
        step;
        i_Rst = 1'b0;

        // Back-to-back writes in vertical blanking: grant every 2nd cycle.
        row = 10'd490; col = 10'd0;
        wr_req = 1'b1; wr_addr = 13'd81; wr_data = 8'h5A;
        step;
        check("burst1", 32'({mem_we, wr_ack, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 13'd81, 8'h5A}));
        wr_addr = 13'd82; wr_data = 8'hC3;
        step;
        check("burst2_blocked", 32'({mem_we, wr_ack}), 32'd0);
        step;
        check("burst3", 32'({mem_we, wr_ack, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 13'd82, 8'hC3}));
        wr_addr = 13'd5000; wr_data = 8'hFF;
        step;
        check("burst4_blocked", 32'({mem_we, wr_ack}), 32'd0);
        step;
        check("oor_ack", 32'(wr_ack), 32'd1);
        check("oor_we", 32'(mem_we), 32'd0);
        wr_req = 1'b0;
        step;
        step;
        check("burst_wr_cnt", 32'(wr_cnt), 32'd2);
        check("ram81", 32'(ram[81]), 32'h5A);
        check("ram82", 32'(ram[82]), 32'hC3);
        check("ram5000", 32'(ram[5000]), 32'h00);

        // Scan row 8, cols 8..25: cells 81 then 82, two-edge latency.
        row = 10'd8;
        for (int c = 8; c < 26; c++) begin
            col = 10'(c);
            step;
            if (c == 8)  check("disp_addr81", 32'({mem_we, mem_addr}), 32'd81);
            if (c == 16) check("disp_addr82", 32'({mem_we, mem_addr}), 32'd82);
            if (c < 10) begin
                check("disp_lat_active", 32'(active), 32'd0);
                check("disp_lat_pixel", 32'(pixel), 32'd0);
            end else begin
                check("disp_active", 32'(active), 32'd1);
                check("disp_pixel", 32'(pixel), (c < 18) ? 32'h5A : 32'hC3);
            end
        end

        // Request first sampled at a display slot: slot wins, grant next edge.
        row = 10'd0; col = 10'd16;
        wr_req = 1'b1; wr_addr = 13'd100; wr_data = 8'h11;
        step;
        check("coll_slot", 32'({mem_we, wr_ack, mem_addr}), 32'({1'b0, 1'b0, 13'd2}));
        col = 10'd17;
        step;
        check("coll_grant", 32'({mem_we, wr_ack, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 13'd100, 8'h11}));
        wr_req = 1'b0; col = 10'd18;
        step;
        check("coll_ack_pulse", 32'({mem_we, wr_ack}), 32'd0);

        // Mid-frame asynchronous reset with a request pending.
        row = 10'd200;
        for (int c = 296; c < 300; c++) begin
            col = 10'(c);
            step;
        end
        check("pre_rst_active", 32'(active), 32'd1);
        col = 10'd300;
        wr_req = 1'b1; wr_addr = 13'd200; wr_data = 8'h22;
        #2;
        i_Rst = 1'b1;
        #1;
        check("midrst_outs", {mem_addr, mem_we, mem_wdata, wr_ack, pixel, active}, 32'd0);
        step;
        check("midrst_no_ack", 32'(wr_ack), 32'd0);
        i_Rst = 1'b0;
        step;
        check("post_rst_grant", 32'({mem_we, wr_ack, mem_addr}), 32'({1'b1, 1'b1, 13'd200}));
        wr_req = 1'b0; col = 10'd301;
        step;

        // Request raised during the visible frame.
        row = 10'd100; col = 10'd1;
        wr_req = 1'b1; wr_addr = 13'd300; wr_data = 8'h33;
`ifdef FB_ARB_VBLANK_WRITE_ONLY_EN
        for (int i = 0; i < 3; i++) begin
            step;
            check("vb_wait_ack", 32'(wr_ack), 32'd0);
        end
        row = 10'd479;
        step;
        check("vb_wait_479", 32'(wr_ack), 32'd0);
        row = 10'd480;
        step;
        check("vb_grant", 32'({mem_we, wr_ack, mem_addr}), 32'({1'b1, 1'b1, 13'd300}));
`else
        step;
        check("vis_grant", 32'({mem_we, wr_ack, mem_addr}), 32'({1'b1, 1'b1, 13'd300}));
`endif
        wr_req = 1'b0;
        step;
        check("last_ack_pulse", 32'(wr_ack), 32'd0);
        step;

        check("ram100", 32'(ram[100]), 32'h11);
        check("ram200", 32'(ram[200]), 32'h22);
        check("ram300", 32'(ram[300]), 32'h33);
        check("total_wr_cnt", 32'(wr_cnt), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
